// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word hold buffer for gapless streaming.
// Latency: the first bit of a word accepted while idle appears one cycle after accept.
// Backpressure: ready_o drops while the hold buffer is full and while reset is high.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             sdata_o,
  output logic             svalid_o,
  output logic             slast_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Registered state
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;

  // Next-state values
  state_t           state_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] hold_nxt;
  logic             hold_full_nxt;

  logic             accept;
  logic             last_bit;
  logic             cur_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // Handshake: ready depends only on the hold flag and reset, never on valid_i.
  assign ready_o  = ~hold_full & ~reset;
  assign accept   = valid_i & ready_o;

  // The bit on the wire is always at the outgoing end of the shifter; the
  // counter only tracks how many bits of the current word have gone out.
  assign cur_bit       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign last_bit      = (state == SHIFT) && (cnt == LAST_CNT);

  // Outputs are masked to zero while idle so downstream sees clean zeros.
  assign svalid_o = (state == SHIFT);
  assign busy_o   = (state == SHIFT);
  assign slast_o  = last_bit;
  assign sdata_o  = svalid_o & cur_bit;

  // Next-state logic: load / buffer / bypass / drain decisions.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    shreg_nxt     = shreg;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;

    unique case (state)
      IDLE: begin
        // Shifter empty: an accepted word goes straight into the shifter.
        if (accept) begin
          shreg_nxt = data_i;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (!last_bit) begin
          shreg_nxt = shreg_shifted;
          cnt_nxt   = cnt + CW'(1);
          // Mid-word accept parks the word in the hold buffer.
          if (accept) begin
            hold_nxt      = data_i;
            hold_full_nxt = 1'b1;
          end
        end else if (hold_full) begin
          // Hold buffer has priority; ready_o is low so no accept can collide.
          shreg_nxt     = hold;
          hold_nxt      = '0;
          hold_full_nxt = 1'b0;
          cnt_nxt       = '0;
        end else if (accept) begin
          // Bypass straight into the shifter to avoid a bubble.
          shreg_nxt = data_i;
          cnt_nxt   = '0;
        end else begin
          shreg_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register with synchronous reset that drops any in-flight word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0: 0 = transmit bit 0 first, 1 = transmit bit WIDTH-1 first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 data_i  input  WIDTH  parallel word offered by the upstream writer.
REQ-006 valid_i  input  1  data_i is valid this cycle.
REQ-007 ready_o  output  1  block can accept a word this cycle.
REQ-008 sdata_o  output  1  serial data bit.
REQ-009 svalid_o  output  1  sdata_o carries a valid bit this cycle.
REQ-010 slast_o  output  1  sdata_o is the final bit of the current word.
REQ-011 busy_o  output  1  shifter holds a word in transmission.

Function
REQ-012 The block SHALL hold a word on each cycle where valid_i and ready_o are both 1 (accept); there is no other transfer condition.
REQ-013 Storage SHALL be one shift register, a bit counter (0..WIDTH-1) and one hold buffer with a full flag.
REQ-014 States: IDLE (shifter empty) and SHIFT (shifter transmitting).
REQ-015 ready_o SHALL equal NOT hold_full AND NOT reset, and SHALL be a function of registered state only; ready_o SHALL NOT depend on valid_i.
REQ-016 In IDLE, an accepted word SHALL load the shifter directly, with counter set to 0 and state set to SHIFT; the hold buffer SHALL remain empty.
REQ-017 Latency: the first bit of a word accepted in IDLE SHALL appear on sdata_o with svalid_o=1 in the cycle after accept.
REQ-018 In SHIFT, svalid_o SHALL be 1 on every cycle; sdata_o SHALL present the bit selected by the counter per MSB_FIRST; the counter SHALL increment by 1 per cycle.
REQ-019 slast_o SHALL be 1 exactly when in SHIFT with counter = WIDTH-1; otherwise 0.
REQ-020 In SHIFT, if the current cycle is not the last-bit cycle, an accepted word SHALL be written to the hold buffer and hold_full SHALL be set.
REQ-021 On the last-bit cycle with hold_full=1, the hold buffer SHALL move into the shifter at the next edge, with counter set to 0, state remaining SHIFT and hold_full cleared; there SHALL be no idle bubble.
REQ-022 On the last-bit cycle with hold_full=0 and an accept in the same cycle, the accepted word SHALL load the shifter directly (bypass), with no bubble.
REQ-023 On the last-bit cycle with hold_full=0 and no accept, state SHALL return to IDLE.
REQ-024 In IDLE, svalid_o, slast_o and sdata_o SHALL be 0; busy_o SHALL be 1 exactly in SHIFT.
REQ-025 data_i SHALL be captured only on accept; later changes of data_i SHALL NOT affect transmitted bits.
REQ-026 Sustained valid_i=1 SHALL yield continuous svalid_o=1 (100% serial throughput).

Reset
REQ-027 While reset=1 at an edge, the block SHALL set state=IDLE, counter=0, hold_full=0 and shifter/hold contents to 0; outputs SHALL read svalid_o=0, slast_o=0, sdata_o=0, busy_o=0.
REQ-028 ready_o SHALL be 0 in every cycle where reset=1, and no accept SHALL occur in such a cycle.
REQ-029 Reset asserted mid-word SHALL discard the in-flight word and the hold buffer with no partial completion; slast_o SHALL NOT be issued for the aborted word.
REQ-030 The first cycle after reset deassertion SHALL show IDLE with ready_o=1.

Verification
REQ-031 Reset held for 2 cycles, then released -> during reset ready_o=0 and svalid/slast/sdata/busy all 0; in the first cycle after release ready_o=1.
REQ-032 WIDTH=8, MSB_FIRST=0, accept 0xA5 at cycle 0 -> cycles 1..8 show sdata_o=1,0,1,0,0,1,0,1 with svalid_o=1; slast_o=1 only at cycle 8; busy_o=0 at cycle 9.
REQ-033 Words 0x01 then 0x80 with valid_i held high -> 16 contiguous svalid_o cycles showing bits 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1; ready_o=0 from the cycle after 0x80 is buffered until the cycle after 0x80 loads.
REQ-034 Accept 0x3C exactly on the last-bit cycle of 0xFF with hold empty -> the first bit of 0x3C (0) follows on the next cycle with svalid_o continuous.
REQ-035 0xFF transmitting with 0x55 held; reset pulsed at bit 3 -> svalid_o=0 and ready_o=1 after release; a next word 0x0F transmits cleanly as 1,1,1,1,0,0,0,0.
REQ-036 MSB_FIRST=1, accept 0xC0 -> sdata_o=1,1,0,0,0,0,0,0 with slast_o on the 8th bit.
